pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter / fetch-address generator for the CPU core. Holds
//  the architectural PC, selects the next PC (sequential, branch, JALR, JAL, trap)
//  and issues fetch addresses to instruction memory with a valid/ready handshake.
//  Adds stall, halt/resume, trap redirect and a boot state to the basic PC register.
// PARAMETERS
//  XLEN          32            PC / address width in bits
//  INST_BYTES    4             instruction size in bytes; power of two, >=2
//  RESET_VECTOR  32'h0000_0000 PC loaded on reset (XLEN bits, INST_BYTES-aligned)
// PORTS
//  clk           in   1     core clock, rising edge
//  reset_n       in   1     asynchronous, active-low reset
//  imem_ready    in   1     instruction memory accepts the current fetch
//  stall         in   1     pipeline stall: hold PC (ignored for traps)
//  branch        in   2     00 seq, 01 conditional, 10 JALR, 11 JAL
//  taken         in   1     conditional branch outcome (used only when branch==01)
//  pc_branch     in   XLEN  branch/jump target
//  trap_req      in   1     redirect to trap_vector
//  trap_vector   in   XLEN  trap handler address
//  halt_req      in   1     request halt; deassert to resume
//  pc            out  XLEN  current fetch address
//  pc_plus       out  XLEN  pc + INST_BYTES (combinational, wraps mod 2^XLEN)
//  pc_valid      out  1     pc is a valid fetch request
//  redirect      out  1     1-cycle pulse: last PC update was non-sequential
//  halted        out  1     unit is in HALT
//  misalign_err  out  1     1-cycle pulse on misaligned target (macro only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=BOOT, pc=RESET_VECTOR, pc_valid=0,
//    redirect=0, halted=0, misalign_err=0. Reset mid-operation aborts everything.
//  - FSM states BOOT, RUN, HALT:
//    BOOT: one cycle, pc_valid=0, -> RUN unconditionally (pc unchanged).
//    RUN : pc_valid=1. "advance" = imem_ready & ~stall.
//    HALT: pc_valid=0, halted=1, pc held; halt_req=0 -> RUN next cycle.
//  - Priority each cycle in RUN: trap_req > halt_req > advance > hold.
//    trap_req: pc<=trap_vector, redirect=1, stay RUN; overrides stall/imem_ready.
//    halt_req (no trap): -> HALT, pc held (halts before the next fetch).
//    advance: next PC by branch: 00 -> pc_plus; 01 -> taken?pc_branch:pc_plus;
//      10 -> {pc_branch[XLEN-1:1],1'b0}; 11 -> pc_branch. redirect=1 iff the
//      selected target is not pc_plus's source path (01 taken, 10, 11).
//    hold (no advance): pc, state unchanged, redirect=0; branch inputs ignored.
//  - trap_req in HALT: pc<=trap_vector, -> RUN, redirect=1. trap_req in BOOT: takes
//    effect, pc<=trap_vector, -> RUN.
//  - Latency: next PC visible on pc one cycle after the advancing edge.
//  - Arithmetic: pc_plus = pc + INST_BYTES modulo 2^XLEN (all-ones region wraps to 0).
//  - Fetch handshake: pc stable while pc_valid & ~imem_ready.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: a taken target (01 taken/10/11) with
//    target[log2(INST_BYTES)-1:0]!=0 is not loaded; instead pc<=trap_vector,
//    misalign_err=1 and redirect=1 for one cycle. trap_req still has priority.
//  Not defined: target low log2(INST_BYTES) bits forced to 0 before loading;
//    misalign_err tied 0.
// TESTING
//  1 reset_n low mid-run, release -> pc=RESET_VECTOR, pc_valid=0 one cycle, then 1.
//  2 branch=00, imem_ready=1, stall=0 x3 from 0 -> pc 4,8,C; stall=1 -> pc holds C.
//  3 branch=01 taken=1 pc_branch=0x100 -> pc=0x100, redirect=1; taken=0 -> pc+4.
//  4 branch=10 pc_branch=0x203 -> pc=0x200 (macro off) / trap_vector+misalign_err (on).
//  5 trap_req=1 with stall=1, trap_vector=0x80 -> pc=0x80 next cycle, redirect=1.
//  6 pc=0xFFFF_FFFC, seq advance -> pc=0; halt_req=1 -> halted=1, pc_valid=0, pc held.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-address generator with boot, run and halt modes.
// Build option: define PC_MISALIGN_TRAP_EN to trap on misaligned jump targets instead of truncating them.
module pc_fetch_unit #(
   parameter int              XLEN         = 32,
   parameter int              INST_BYTES   = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_imem_ready,
   input  logic            i_stall,
   input  logic [1:0]      i_branch,
   input  logic            i_taken,
   input  logic [XLEN-1:0] i_pc_branch,
   input  logic            i_trap_req,
   input  logic [XLEN-1:0] i_trap_vector,
   input  logic            i_halt_req,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus,
   output logic            o_pc_valid,
   output logic            o_redirect,
   output logic            o_halted,
   output logic            o_misalign_err
);

   // state  | meaning
   // S_BOOT | first cycle out of reset, no fetch issued
   // S_RUN  | fetching; pc_valid asserted
   // S_HALT | stopped, pc held until halt_req drops or a trap arrives
   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam int              LSB        = $clog2(INST_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_pc_plus;
   logic [XLEN-1:0] w_target;
   logic            w_jump;
   logic            w_advance;
   logic            r_redirect;
   logic            w_redirect_nxt;
`ifdef PC_MISALIGN_TRAP_EN
   logic            r_misalign;
   logic            w_misalign_nxt;
   logic            w_misaligned;
`endif

   assign w_pc_plus = r_pc + XLEN'(INST_BYTES);
   assign w_advance = i_imem_ready & ~i_stall;
   assign w_jump    = ((i_branch == 2'b01) & i_taken) | i_branch[1];

   always_comb begin
      w_target = i_pc_branch;
      if (i_branch == 2'b10) w_target = {i_pc_branch[XLEN-1:1], 1'b0};
   end

`ifdef PC_MISALIGN_TRAP_EN
   assign w_misaligned = |w_target[LSB-1:0];
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_redirect_nxt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      w_misalign_nxt = 1'b0;
`endif
      case (r_state)
         S_BOOT: begin
            w_state_nxt = S_RUN;
            if (i_trap_req) begin
               w_pc_nxt       = i_trap_vector;
               w_redirect_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (i_trap_req) begin
               w_pc_nxt       = i_trap_vector;
               w_redirect_nxt = 1'b1;
            end else if (i_halt_req) begin
               w_state_nxt = S_HALT;
            end else if (w_advance) begin
               if (!w_jump) begin
                  w_pc_nxt = w_pc_plus;
               end else begin
                  w_redirect_nxt = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                  if (w_misaligned) begin
                     w_pc_nxt       = i_trap_vector;
                     w_misalign_nxt = 1'b1;
                  end else begin
                     w_pc_nxt = w_target;
                  end
`else
                  w_pc_nxt = w_target & ALIGN_MASK;
`endif
               end
            end
         end
         S_HALT: begin
            if (i_trap_req) begin
               w_state_nxt    = S_RUN;
               w_pc_nxt       = i_trap_vector;
               w_redirect_nxt = 1'b1;
            end else if (!i_halt_req) begin
               w_state_nxt = S_RUN;
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_VECTOR;
         r_redirect <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_redirect <= w_redirect_nxt;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_misalign <= 1'b0;
      else            r_misalign <= w_misalign_nxt;
   end
   assign o_misalign_err = r_misalign;
`else
   assign o_misalign_err = 1'b0;
`endif

   assign o_pc       = r_pc;
   assign o_pc_plus  = w_pc_plus;
   assign o_pc_valid = (r_state == S_RUN);
   assign o_halted   = (r_state == S_HALT);
   assign o_redirect = r_redirect;

endmodule
